// File: rtl/wwd_display_sink.sv
// ---------------------------------------------------------------------------
// wwd_display_sink
// Receiving end of the CPU WWD output port. Words strobed in by the CPU are
// buffered in a small FIFO and each one is held on a 4-digit multiplexed
// 7-segment display for at least DWELL_CYCLES clocks, so bursts stay legible.
// The CPU is back-pressured through wwd_ready. The CPU PC low byte is
// registered onto the LEDs.
//
// Optional build macro: WWD_DISPLAY_OVERRIDE_EN
//   Adds override_valid/override_data. While override_valid is high the
//   display scans override_data, the dwell timer freezes and no pops occur
//   (pushes still accepted).
//
// Ports
//   clk             system clock, rising edge
//   reset_cpu       asynchronous active-high reset
//   wwd_valid       one-cycle strobe, wwd_data offered this cycle
//   wwd_data[15:0]  word to display
//   wwd_ready       combinational, high while the FIFO is not full
//   pc_in[7:0]      CPU PC low byte
//   pc_led[7:0]     registered copy of pc_in
//   seg[6:0]        active-low segments {g,f,e,d,c,b,a}
//   an[3:0]         active-low digit enables, an[0] is the rightmost digit
//   override_valid  (macro only) select override_data for display
//   override_data   (macro only) word displayed during override
//   fifo_count      current FIFO occupancy
//   overflow        sticky, set when an offered word is dropped
//
// state | meaning
// IDLE  | nothing shown since reset, waiting for the first word
// SHOW  | a word is on display, dwell timer counting down
// HOLD  | dwell expired with FIFO empty, last word stays on display
// ---------------------------------------------------------------------------
module wwd_display_sink #(
  parameter int DEPTH        = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int SCAN_CYCLES  = 50000
) (
  input  logic                     clk,
  input  logic                     reset_cpu,
  input  logic                     wwd_valid,
  input  logic [15:0]              wwd_data,
  output logic                     wwd_ready,
  input  logic [7:0]               pc_in,
  output logic [7:0]               pc_led,
  output logic [6:0]               seg,
  output logic [3:0]               an,
`ifdef WWD_DISPLAY_OVERRIDE_EN
  input  logic                     override_valid,
  input  logic [15:0]              override_data,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_dwell;
  logic [15:0]   r_shown;

  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_digit;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic [7:0]    r_pc_led;

  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_empty;
  logic          w_freeze;
  logic          w_dwell_load;
  logic          w_dwell_dec;
  logic          w_scan_wrap;
  logic [1:0]    w_digit_next;
  logic [15:0]   w_shown_next;
  logic [15:0]   w_disp_next;
  logic [3:0]    w_nibble;

`ifdef WWD_DISPLAY_OVERRIDE_EN
  assign w_freeze = override_valid;
`else
  assign w_freeze = 1'b0;
`endif

  // Ready reflects the pre-edge count, so a push into a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign wwd_ready  = (r_count != FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = wwd_valid & wwd_ready;
  assign w_drop     = wwd_valid & ~wwd_ready;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign pc_led     = r_pc_led;
  assign an         = r_an;
  assign seg        = r_seg;

  // FIFO storage and pointers
  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wwd_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Display sequencing FSM: state register
  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      r_state <= IDLE;
      r_dwell <= '0;
      r_shown <= '0;
    end else begin
      r_state <= w_state_next;
      r_shown <= w_shown_next;
      if (w_dwell_load)     r_dwell <= DWELL_LOAD;
      else if (w_dwell_dec) r_dwell <= r_dwell - DW'(1);
    end
  end

  // Display sequencing FSM: next state and pop decision
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_dwell_load = 1'b0;
    w_dwell_dec  = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        if (!w_empty && !w_freeze) begin
          w_pop        = 1'b1;
          w_dwell_load = 1'b1;
          w_state_next = SHOW;
        end
      end
      SHOW: begin
        if (r_dwell != '0) begin
          w_dwell_dec = ~w_freeze;
        end else if (!w_empty) begin
          // dwell expired with more queued: swap straight to the next word
          if (!w_freeze) begin
            w_pop        = 1'b1;
            w_dwell_load = 1'b1;
          end
        end else begin
          w_state_next = HOLD;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_shown_next = w_pop ? r_mem[r_rd_ptr] : r_shown;

  // seg is built from the post-edge word so a freshly popped word appears on
  // the same edge it is popped.
`ifdef WWD_DISPLAY_OVERRIDE_EN
  assign w_disp_next = w_freeze ? override_data : w_shown_next;
`else
  assign w_disp_next = w_shown_next;
`endif

  assign w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
  assign w_digit_next = w_scan_wrap ? r_digit + 2'd1 : r_digit;

  always_comb begin
    w_nibble = w_disp_next[3:0];
    case (w_digit_next)
      2'd0: w_nibble = w_disp_next[3:0];
      2'd1: w_nibble = w_disp_next[7:4];
      2'd2: w_nibble = w_disp_next[11:8];
      2'd3: w_nibble = w_disp_next[15:12];
      default: w_nibble = w_disp_next[3:0];
    endcase
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit scan; an and seg move together on the same edge
  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd0;
      r_an       <= 4'b1110;
      r_seg      <= 7'h40;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
      r_digit    <= w_digit_next;
      r_an       <= ~(4'b0001 << w_digit_next);
      r_seg      <= hex_to_seg(w_nibble);
    end
  end

  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) r_pc_led <= 8'h00;
    else           r_pc_led <= pc_in;
  end

endmodule

// File: tb/tb_wwd_display_sink.sv
module tb_wwd_display_sink;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int SCAN  = 2;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic        wwd_valid;
  logic [15:0] wwd_data;
  logic        wwd_ready;
  logic [7:0]  pc_in;
  logic [7:0]  pc_led;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [2:0]  fifo_count;
  logic        overflow;
`ifdef WWD_DISPLAY_OVERRIDE_EN
  logic        override_valid;
  logic [15:0] override_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wwd_display_sink #(
    .DEPTH(DEPTH),
    .DWELL_CYCLES(DWELL),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk(clk),
    .reset_cpu(reset_cpu),
    .wwd_valid(wwd_valid),
    .wwd_data(wwd_data),
    .wwd_ready(wwd_ready),
    .pc_in(pc_in),
    .pc_led(pc_led),
    .seg(seg),
    .an(an),
`ifdef WWD_DISPLAY_OVERRIDE_EN
    .override_valid(override_valid),
    .override_data(override_data),
`endif
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  // Reference model: sb_q holds the words expected to be buffered; they are
  // pushed when the bench offers an accepted word and popped into m_shown
  // when the display is due to move on.
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] sb_q [$];
  int          m_state, m_dwell, m_scan, m_digit, m_pre;
  logic        m_frz, m_pop, m_ovf, m_ready;
  logic [15:0] m_shown, m_disp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [2:0]  m_cnt;
  logic [7:0]  m_pc;

  always @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      sb_q.delete();
      m_state = 0; m_dwell = 0; m_scan = 0; m_digit = 0;
      m_shown = 16'h0; m_an = 4'b1110; m_seg = 7'h40;
      m_ovf = 1'b0; m_pc = 8'h00; m_cnt = 3'd0; m_ready = 1'b1;
    end else begin
      m_pre = sb_q.size();
      m_pop = 1'b0;
`ifdef WWD_DISPLAY_OVERRIDE_EN
      m_frz = override_valid;
`else
      m_frz = 1'b0;
`endif
      if (m_state != 1) begin
        if (m_pre != 0 && !m_frz) begin m_pop = 1'b1; m_dwell = DWELL - 1; m_state = 1; end
      end else if (m_dwell != 0) begin
        if (!m_frz) m_dwell = m_dwell - 1;
      end else if (m_pre != 0) begin
        if (!m_frz) begin m_pop = 1'b1; m_dwell = DWELL - 1; end
      end else begin
        m_state = 2;
      end
      if (m_pop) m_shown = sb_q.pop_front();
      if (wwd_valid) begin
        if (m_pre < DEPTH) sb_q.push_back(wwd_data);
        else m_ovf = 1'b1;
      end
      if (m_scan == SCAN - 1) begin m_scan = 0; m_digit = (m_digit + 1) % 4; end
      else m_scan = m_scan + 1;
`ifdef WWD_DISPLAY_OVERRIDE_EN
      m_disp = m_frz ? override_data : m_shown;
`else
      m_disp = m_shown;
`endif
      m_an    = ~(4'b0001 << m_digit);
      m_seg   = hex_tab[m_disp[4*m_digit +: 4]];
      m_pc    = pc_in;
      m_cnt   = 3'(sb_q.size());
      m_ready = (sb_q.size() < DEPTH);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_cpu = 1'b1;
    wwd_valid = 1'b0;
    wwd_data  = 16'h0;
`ifdef WWD_DISPLAY_OVERRIDE_EN
    override_valid = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset_cpu = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    n_checks++; if (wwd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", wwd_ready); end
    n_checks++; if (an !== 4'b1110) begin n_errors++; $display("FAIL reset_an got=%b exp=1110", an); end
    n_checks++; if (seg !== 7'h40) begin n_errors++; $display("FAIL reset_seg got=%h exp=40", seg); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_checks++; if (pc_led !== 8'h00) begin n_errors++; $display("FAIL reset_pc got=%h exp=00", pc_led); end
    reset_cpu = 1'b0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_an;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k / 2) % 4));
      n_checks++; if (an !== exp_an) begin n_errors++; $display("FAIL idle_an k=%0d got=%b exp=%b", k, an, exp_an); end
      n_checks++; if (seg !== 7'h40 || wwd_ready !== 1'b1 || fifo_count !== 3'd0) begin
        n_errors++; $display("FAIL idle_state k=%0d seg=%h rdy=%b cnt=%0d exp seg=40 rdy=1 cnt=0", k, seg, wwd_ready, fifo_count);
      end
    end
  endtask

  task automatic test_single_push();
    logic [6:0] exp_seg;
    do_reset();
    wwd_valid = 1'b1; wwd_data = 16'h1A2F;
    @(negedge clk);
    wwd_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1 || seg !== 7'h40) begin
      n_errors++; $display("FAIL single_edgeN cnt=%0d seg=%h exp cnt=1 seg=40", fifo_count, seg);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: exp_seg = 7'h0E;
        4'b1101: exp_seg = 7'h24;
        4'b1011: exp_seg = 7'h08;
        4'b0111: exp_seg = 7'h79;
        default: exp_seg = 7'hxx;
      endcase
      n_checks++; if (seg !== exp_seg || fifo_count !== 3'd0) begin
        n_errors++; $display("FAIL single_digit i=%0d an=%b seg=%h cnt=%0d exp seg=%h cnt=0", i, an, seg, fifo_count, exp_seg);
      end
      n_checks++; if ({seg, an, fifo_count, wwd_ready, overflow} !== {m_seg, m_an, m_cnt, m_ready, m_ovf}) begin
        n_errors++; $display("FAIL single_model i=%0d got seg=%h an=%b cnt=%0d rdy=%b ovf=%b exp seg=%h an=%b cnt=%0d rdy=%b ovf=%b",
                             i, seg, an, fifo_count, wwd_ready, overflow, m_seg, m_an, m_cnt, m_ready, m_ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int w = 1; w <= 6; w++) begin
      wwd_valid = 1'b1; wwd_data = 16'(w);
      @(negedge clk);
      if (w == 5) begin
        n_checks++; if (wwd_ready !== 1'b0 || fifo_count !== 3'd4) begin
          n_errors++; $display("FAIL b2b_full rdy=%b cnt=%0d exp rdy=0 cnt=4", wwd_ready, fifo_count);
        end
      end
      if (w == 6) begin
        n_checks++; if (overflow !== 1'b1 || fifo_count !== 3'd3) begin
          n_errors++; $display("FAIL b2b_drop ovf=%b cnt=%0d exp ovf=1 cnt=3", overflow, fifo_count);
        end
      end
    end
    wwd_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_checks++; if ({seg, an, fifo_count, wwd_ready, overflow} !== {m_seg, m_an, m_cnt, m_ready, m_ovf}) begin
        n_errors++; $display("FAIL b2b_model i=%0d got seg=%h an=%b cnt=%0d rdy=%b ovf=%b exp seg=%h an=%b cnt=%0d rdy=%b ovf=%b",
                             i, seg, an, fifo_count, wwd_ready, overflow, m_seg, m_an, m_cnt, m_ready, m_ovf);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (seg !== ((an == 4'b1110) ? 7'h12 : 7'h40) || overflow !== 1'b1 || fifo_count !== 3'd0) begin
        n_errors++; $display("FAIL b2b_hold_last i=%0d an=%b seg=%h ovf=%b cnt=%0d exp word 0005 ovf=1 cnt=0", i, an, seg, overflow, fifo_count);
      end
    end
  endtask

  task automatic test_full_pop_same_edge();
    do_reset();
    for (int w = 0; w < 5; w++) begin
      wwd_valid = 1'b1; wwd_data = 16'h00A0 + 16'(w);
      @(negedge clk);
    end
    n_checks++; if (fifo_count !== 3'd4 || wwd_ready !== 1'b0 || overflow !== 1'b0) begin
      n_errors++; $display("FAIL fullpop_pre cnt=%0d rdy=%b ovf=%b exp cnt=4 rdy=0 ovf=0", fifo_count, wwd_ready, overflow);
    end
    wwd_data = 16'hDEAD;
    @(negedge clk);
    wwd_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd3 || overflow !== 1'b1) begin
      n_errors++; $display("FAIL fullpop_post cnt=%0d ovf=%b exp cnt=3 ovf=1", fifo_count, overflow);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if ({seg, an, fifo_count, wwd_ready, overflow} !== {m_seg, m_an, m_cnt, m_ready, m_ovf}) begin
        n_errors++; $display("FAIL fullpop_model i=%0d got seg=%h an=%b cnt=%0d exp seg=%h an=%b cnt=%0d",
                             i, seg, an, fifo_count, m_seg, m_an, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    for (int w = 1; w <= 4; w++) begin
      wwd_valid = 1'b1; wwd_data = 16'h0111 * 16'(w);
      @(negedge clk);
    end
    wwd_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd3) begin n_errors++; $display("FAIL midrst_pre cnt=%0d exp=3", fifo_count); end
    #2 reset_cpu = 1'b1;
    #1;
    n_checks++; if (fifo_count !== 3'd0 || seg !== 7'h40 || an !== 4'b1110 || overflow !== 1'b0 || wwd_ready !== 1'b1) begin
      n_errors++; $display("FAIL midrst_async cnt=%0d seg=%h an=%b ovf=%b rdy=%b exp cnt=0 seg=40 an=1110 ovf=0 rdy=1",
                           fifo_count, seg, an, overflow, wwd_ready);
    end
    @(negedge clk);
    reset_cpu = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++; if (seg !== 7'h40 || fifo_count !== 3'd0 || {seg, an} !== {m_seg, m_an}) begin
        n_errors++; $display("FAIL midrst_after i=%0d seg=%h an=%b cnt=%0d exp seg=40 an=%b cnt=0", i, seg, an, fifo_count, m_an);
      end
    end
  endtask

  task automatic test_pc_led();
    @(negedge clk);
    pc_in = 8'hA5;
    #1;
    n_checks++; if (pc_led !== 8'h00) begin n_errors++; $display("FAIL pc_before got=%h exp=00", pc_led); end
    @(negedge clk);
    n_checks++; if (pc_led !== 8'hA5) begin n_errors++; $display("FAIL pc_A5 got=%h exp=A5", pc_led); end
    pc_in = 8'h5A;
    @(negedge clk);
    n_checks++; if (pc_led !== 8'h5A) begin n_errors++; $display("FAIL pc_5A got=%h exp=5A", pc_led); end
  endtask

`ifdef WWD_DISPLAY_OVERRIDE_EN
  task automatic test_override();
    logic [6:0] exp_seg;
    do_reset();
    wwd_valid = 1'b1; wwd_data = 16'h1234;
    @(negedge clk);
    wwd_valid = 1'b0;
    repeat (2) @(negedge clk);
    override_valid = 1'b1; override_data = 16'hBEEF;
    wwd_valid = 1'b1; wwd_data = 16'h5678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wwd_valid = 1'b0;
      case (an)
        4'b1110: exp_seg = 7'h0E;
        4'b1101: exp_seg = 7'h06;
        4'b1011: exp_seg = 7'h06;
        4'b0111: exp_seg = 7'h03;
        default: exp_seg = 7'hxx;
      endcase
      n_checks++; if (seg !== exp_seg || fifo_count !== 3'd1) begin
        n_errors++; $display("FAIL ovr_digit i=%0d an=%b seg=%h cnt=%0d exp seg=%h cnt=1", i, an, seg, fifo_count, exp_seg);
      end
    end
    override_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_checks++; if ({seg, an, fifo_count} !== {m_seg, m_an, m_cnt}) begin
        n_errors++; $display("FAIL ovr_release i=%0d got seg=%h an=%b cnt=%0d exp seg=%h an=%b cnt=%0d",
                             i, seg, an, fifo_count, m_seg, m_an, m_cnt);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_cpu = 1'b1;
    wwd_valid = 1'b0;
    wwd_data  = 16'h0;
    pc_in     = 8'h00;
`ifdef WWD_DISPLAY_OVERRIDE_EN
    override_valid = 1'b0;
    override_data  = 16'h0;
`endif
    test_reset();
    test_idle_scan();
    test_single_push();
    test_back_to_back();
    test_full_pop_same_edge();
    test_reset_mid_show();
    test_pc_led();
`ifdef WWD_DISPLAY_OVERRIDE_EN
    test_override();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
